// File: rtl/noc_output_port_arbiter_pkg.sv
// Shared types and helpers for the NoC output-port arbiter.
// Pure declarations: no clocked logic and no flow control.
package noc_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int DEFAULT_CREDIT_DEPTH    = 1;
  localparam int DEFAULT_WATCHDOG_CYCLES = 255;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/noc_output_port_arbiter_if.sv
// Request/grant/credit bundle between input ports, crossbar and one output-port arbiter.
// The arbiter sits on the slave modport; the input-port side drives the master modport.
interface noc_output_port_arbiter_if #(
  parameter int NUM_INPUTS   = 5,
  parameter int CREDIT_DEPTH = 1,
  parameter int SEL_WIDTH    = $clog2(NUM_INPUTS),
  parameter int CNT_WIDTH    = $clog2(CREDIT_DEPTH + 1)
);
  logic [NUM_INPUTS-1:0] in_valid;
  logic [NUM_INPUTS-1:0] in_is_tail;
  logic [NUM_INPUTS-1:0] disable_turn;
  logic                  credit_in;
  logic [NUM_INPUTS-1:0] in_pop;
  logic                  grant_valid;
  logic [SEL_WIDTH-1:0]  grant_sel;
  logic                  send_out;
  logic [CNT_WIDTH-1:0]  credit_count;
  logic                  credit_overflow;
  logic                  watchdog_err;

  modport master (
    output in_valid, in_is_tail, disable_turn, credit_in,
    input  in_pop, grant_valid, grant_sel, send_out, credit_count, credit_overflow, watchdog_err
  );

  modport slave (
    input  in_valid, in_is_tail, disable_turn, credit_in,
    output in_pop, grant_valid, grant_sel, send_out, credit_count, credit_overflow, watchdog_err
  );
endinterface

// File: rtl/noc_output_port_arbiter_picker.sv
// Round-robin priority picker: first set elig bit at or after rr_ptr, wrapping.
// Purely combinational; no backpressure.
module rr_priority_picker #(
  parameter int N         = 5,
  parameter int SEL_WIDTH = $clog2(N)
) (
  input  logic [N-1:0]         elig,
  input  logic [SEL_WIDTH-1:0] rr_ptr,
  output logic                 any_valid,
  output logic [SEL_WIDTH-1:0] pick
);
  always_comb begin
    int idx;
    any_valid = |elig;
    pick      = '0;
    idx       = 0;
    // Scan from the farthest offset down so the nearest eligible index wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N;
      if (elig[idx]) pick = SEL_WIDTH'(idx);
    end
  end
endmodule

// File: rtl/noc_output_port_arbiter.sv
// Wormhole round-robin output-port arbiter with downstream credit tracking; optional NOC_ARB_WATCHDOG_EN stall watchdog.
// Grant 1 cycle after request; pops stall (lock held) while credits are 0 or the owner's valid is low.
module noc_output_port_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_INPUTS      = 5,
  parameter int CREDIT_DEPTH    = DEFAULT_CREDIT_DEPTH,
  parameter int SEL_WIDTH       = $clog2(NUM_INPUTS),
  parameter int CNT_WIDTH       = $clog2(CREDIT_DEPTH + 1),
  parameter int WATCHDOG_CYCLES = DEFAULT_WATCHDOG_CYCLES
) (
  input logic                   clk_noc,
  input logic                   rst_noc_sync,
  noc_output_port_arbiter_if.slave arb
);
  localparam logic [CNT_WIDTH-1:0] CRED_FULL = CNT_WIDTH'(CREDIT_DEPTH);

  arb_state_t            state, state_nxt;
  logic [SEL_WIDTH-1:0]  sel_q, sel_nxt;
  logic [SEL_WIDTH-1:0]  rr_ptr, rr_nxt;
  logic [CNT_WIDTH-1:0]  cred_q, cred_nxt;
  logic                  ovf_q, ovf_nxt;
  logic [NUM_INPUTS-1:0] elig;
  logic                  any_valid;
  logic [SEL_WIDTH-1:0]  pick;
  logic                  pop;
  logic                  wd_fire;

  assign elig = arb.in_valid & ~arb.disable_turn;

  rr_priority_picker #(.N(NUM_INPUTS), .SEL_WIDTH(SEL_WIDTH)) u_picker (
    .elig      (elig),
    .rr_ptr    (rr_ptr),
    .any_valid (any_valid),
    .pick      (pick)
  );

  assign pop = !rst_noc_sync && (state == LOCKED) && arb.in_valid[sel_q] && (cred_q != '0);

`ifdef NOC_ARB_WATCHDOG_EN
  localparam int WD_WIDTH = $clog2(WATCHDOG_CYCLES + 1);
  logic [WD_WIDTH-1:0] wd_cnt, wd_nxt;
  logic                wd_err_q;
  logic                stall;

  always_comb begin
    stall   = (state == LOCKED) && !arb.in_valid[sel_q];
    wd_fire = stall && (wd_cnt == WD_WIDTH'(WATCHDOG_CYCLES - 1));
    wd_nxt  = wd_cnt;
    if (state != LOCKED || pop || wd_fire) wd_nxt = '0;
    else if (stall)                        wd_nxt = wd_cnt + WD_WIDTH'(1);
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      wd_cnt   <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt <= wd_nxt;
      if (wd_fire) wd_err_q <= 1'b1;
    end
  end

  assign arb.watchdog_err = wd_err_q;
`else
  assign wd_fire          = 1'b0;
  assign arb.watchdog_err = (WATCHDOG_CYCLES < 0);
`endif

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_nxt = LOCKED;
          sel_nxt   = pick;
        end
      end
      LOCKED: begin
        // The turn mask is deliberately ignored here: a packet in flight is never cut.
        if ((pop && arb.in_is_tail[sel_q]) || wd_fire) begin
          state_nxt = IDLE;
          rr_nxt    = SEL_WIDTH'(ptr_inc(32'(sel_q), NUM_INPUTS));
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cred_nxt = cred_q;
    ovf_nxt  = ovf_q;
    if (pop && !arb.credit_in) begin
      cred_nxt = cred_q - CNT_WIDTH'(1);
    end else if (!pop && arb.credit_in) begin
      if (cred_q == CRED_FULL) ovf_nxt  = 1'b1;
      else                     cred_nxt = cred_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      state  <= IDLE;
      sel_q  <= '0;
      rr_ptr <= '0;
      cred_q <= CRED_FULL;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      sel_q  <= sel_nxt;
      rr_ptr <= rr_nxt;
      cred_q <= cred_nxt;
      ovf_q  <= ovf_nxt;
    end
  end

  assign arb.in_pop          = pop ? (NUM_INPUTS'(1) << sel_q) : '0;
  assign arb.send_out        = pop;
  assign arb.grant_valid     = (state == LOCKED);
  assign arb.grant_sel       = sel_q;
  assign arb.credit_count    = cred_q;
  assign arb.credit_overflow = ovf_q;
endmodule

// File: tb/tb_noc_output_port_arbiter.sv
// Scoreboard bench: directed test-plan scenarios plus randomized traffic against a behavioural model.
module tb_noc_output_port_arbiter;
  localparam int N     = 5;
  localparam int DEPTH = 4;
  localparam int WD    = 8;

  typedef struct {
    logic [N-1:0] pop;
    logic         gv;
    logic [2:0]   sel;
    int           cred;
    logic         ovf;
    logic         wd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   pop_log[$];

  // Behavioural model state
  bit m_locked;
  int m_owner, m_ptr, m_cred, m_wd;
  bit m_ovf, m_wd_err;

  noc_output_port_arbiter_if #(.NUM_INPUTS(N), .CREDIT_DEPTH(DEPTH)) arb_if ();

  noc_output_port_arbiter #(
    .NUM_INPUTS(N), .CREDIT_DEPTH(DEPTH), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk_noc      (clk),
    .rst_noc_sync (rst),
    .arb          (arb_if)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int count_pops(input int who);
    int c = 0;
    foreach (pop_log[i]) if (pop_log[i] == who) c++;
    return c;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = DEPTH;
    m_ovf = 0; m_wd = 0; m_wd_err = 0;
  endtask

  task automatic model_release();
    m_locked = 0;
    m_ptr    = (m_owner + 1) % N;
  endtask

  // Push this cycle's expected outputs, then advance the model across the coming edge.
  task automatic step(input logic [N-1:0] v, t, d, input logic ci, r);
    exp_t e;
    bit   pop_b;
    pop_b  = !r && m_locked && v[m_owner] && (m_cred > 0);
    e.pop  = pop_b ? N'(1 << m_owner) : '0;
    e.gv   = m_locked;
    e.sel  = 3'(m_owner);
    e.cred = m_cred;
    e.ovf  = m_ovf;
    e.wd   = m_wd_err;
    q.push_back(e);
    if (r) begin
      model_reset();
      return;
    end
    if (pop_b && !ci) m_cred--;
    else if (ci && !pop_b) begin
      if (m_cred == DEPTH) m_ovf = 1;
      else m_cred++;
    end
    if (!m_locked) begin
      m_wd = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (v[idx] && !d[idx]) begin
          m_locked = 1;
          m_owner  = idx;
          break;
        end
      end
    end else if (pop_b) begin
      m_wd = 0;
      if (t[m_owner]) model_release();
    end else if (!v[m_owner]) begin
`ifdef NOC_ARB_WATCHDOG_EN
      m_wd++;
      if (m_wd == WD) begin
        m_wd     = 0;
        m_wd_err = 1;
        model_release();
      end
`endif
    end
  endtask

  task automatic cyc(input logic [N-1:0] v, t, d, input logic ci, input logic r = 1'b0);
    @(posedge clk);
    #1;
    arb_if.in_valid     = v;
    arb_if.in_is_tail   = t;
    arb_if.disable_turn = d;
    arb_if.credit_in    = ci;
    rst                 = r;
    step(v, t, d, ci, r);
  endtask

  // Downstream returns a credit only when it actually holds a flit.
  function automatic logic ret(input bit en);
    return en && (m_cred < DEPTH);
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("in_pop", arb_if.in_pop, e.pop);
        chk("send_out", arb_if.send_out, |e.pop);
        chk("grant_valid", arb_if.grant_valid, e.gv);
        chk("grant_sel", arb_if.grant_sel, e.sel);
        chk("credit_count", arb_if.credit_count, e.cred);
        chk("credit_overflow", arb_if.credit_overflow, e.ovf);
        chk("watchdog_err", arb_if.watchdog_err, e.wd);
        if (|arb_if.in_pop) pop_log.push_back(onehot_idx(arb_if.in_pop));
      end
    end
  end

  initial begin : stimulus
    int fair_exp[6] = '{0, 1, 3, 0, 1, 3};
    arb_if.in_valid = '0; arb_if.in_is_tail = '0; arb_if.disable_turn = '0; arb_if.credit_in = 1'b0;
    model_reset();
    @(posedge clk);
    cyc('0, '0, '0, 1'b0, 1'b1);
    cyc('0, '0, '0, 1'b0);

    // Single 3-flit packet from input 2, no credits returned
    cyc(5'b00100, 5'b00000, '0, 1'b0);
    cyc(5'b00100, 5'b00000, '0, 1'b0);
    cyc(5'b00100, 5'b00000, '0, 1'b0);
    cyc(5'b00100, 5'b00100, '0, 1'b0);
    cyc('0, '0, '0, 1'b0);
    chk("single_credits_left", arb_if.credit_count, 1);
    chk("single_released", arb_if.grant_valid, 0);
    chk("single_pops_in2", count_pops(2), 3);

    // Credit stall: input 4 two-flit packet with one credit, return held back 5 cycles
    pop_log.delete();
    cyc(5'b10000, 5'b00000, '0, 1'b0);
    cyc(5'b10000, 5'b00000, '0, 1'b0);
    repeat (5) cyc(5'b10000, 5'b10000, '0, 1'b0);
    chk("stall_lock_held", arb_if.grant_valid, 1);
    chk("stall_one_pop", count_pops(4), 1);
    cyc(5'b10000, 5'b10000, '0, 1'b1);
    cyc(5'b10000, 5'b10000, '0, 1'b0);
    cyc('0, '0, '0, 1'b0);
    chk("stall_two_pops", count_pops(4), 2);
    repeat (DEPTH) cyc('0, '0, '0, ret(1));

    // Fairness among inputs 0, 1, 3 with 1-flit packets
    pop_log.delete();
    repeat (12) cyc(5'b01011, 5'b01011, '0, ret(1));
    cyc('0, '0, '0, ret(1));
    chk("fair_pop_count", pop_log.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < pop_log.size()) chk("fair_order", pop_log[i], fair_exp[i]);

    // Turn mask blocks a fresh grant but not a packet already in flight
    pop_log.delete();
    repeat (3) cyc(5'b00010, 5'b00000, 5'b00010, ret(1));
    chk("mask_no_grant", arb_if.grant_valid, 0);
    cyc(5'b00010, 5'b00000, 5'b00000, ret(1));
    cyc(5'b00010, 5'b00000, 5'b00010, ret(1));
    cyc(5'b00010, 5'b00010, 5'b00010, ret(1));
    cyc('0, '0, '0, ret(1));
    chk("mask_packet_done", count_pops(1), 2);

    // Credit returned while full sets the sticky overflow flag
    repeat (DEPTH) cyc('0, '0, '0, ret(1));
    cyc('0, '0, '0, 1'b1);
    cyc('0, '0, '0, 1'b0);
    chk("overflow_set", arb_if.credit_overflow, 1);
    chk("overflow_count_sat", arb_if.credit_count, DEPTH);
    cyc('0, '0, '0, 1'b0, 1'b1);
    cyc('0, '0, '0, 1'b0);
    chk("overflow_cleared_by_reset", arb_if.credit_overflow, 0);

`ifdef NOC_ARB_WATCHDOG_EN
    // Input 0 stalls after its head flit; input 1 waits
    cyc(5'b00011, 5'b00000, '0, 1'b0);
    cyc(5'b00011, 5'b00000, '0, 1'b0);
    repeat (WD) cyc(5'b00010, 5'b00000, '0, 1'b0);
    cyc(5'b00010, 5'b00000, '0, 1'b0);
    cyc('0, '0, '0, 1'b0);
    chk("wd_err_set", arb_if.watchdog_err, 1);
    chk("wd_next_grant_in1", arb_if.grant_sel, 1);
    cyc('0, '0, '0, 1'b0, 1'b1);
`endif

    // Randomized traffic, credits and occasional resets
    repeat (600) begin
      logic [N-1:0] v, t, d;
      v = N'($urandom);
      t = N'($urandom & $urandom);
      d = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      cyc(v, t, d, ret(1'($urandom)), ($urandom_range(0, 149) == 0));
    end
    cyc('0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
